// File: rtl/hidden_cpu_driver.sv
// Host-side instruction sequencer for the HiddenCPU pin interface: drives CPU
// reset/clock plus one 6-bit instruction per CPU clock and captures an output trace.
module hidden_cpu_driver #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = 4,
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    cpu_io_out,
    output logic [7:0]    cpu_io_in,
    output logic          busy,
    output logic          done,
    output logic          trace_valid,
    output logic [7:0]    trace_data
);

    localparam int unsigned IW  = 6;
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST_LO = 3'd1,
        RST_HI = 3'd2,
        EXE_LO = 3'd3,
        EXE_HI = 3'd4,
        FIN    = 3'd5,
        DONE   = 3'd6
    } state_t;

    logic [IW-1:0]  prog [DEPTH];
    state_t         state, state_nxt;
    logic [AW-1:0]  idx, idx_nxt;
    logic [RCW-1:0] rcnt, rcnt_nxt;
    logic [LW-1:0]  len, len_nxt;
    logic [LW-1:0]  len_clamped_c;
    logic [7:0]     io_c;
    logic           busy_c;
    logic           done_c;
    logic           cap_pending;

    assign len_clamped_c = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;

    // State and run counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            rcnt  <= '0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            rcnt  <= rcnt_nxt;
            len   <= len_nxt;
        end
    end

    // Next-state logic; stop overrides every transition out of a busy state
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rcnt_nxt  = rcnt;
        len_nxt   = len;
        if (stop && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop && len_clamped_c != '0) begin
                        state_nxt = RST_LO;
                        idx_nxt   = '0;
                        rcnt_nxt  = '0;
                        len_nxt   = len_clamped_c;
                    end
                end
                RST_LO: state_nxt = RST_HI;
                RST_HI: begin
                    rcnt_nxt  = rcnt + RCW'(1);
                    state_nxt = (rcnt == RCW'(RESET_CYCLES - 1)) ? EXE_LO : RST_LO;
                end
                EXE_LO: state_nxt = EXE_HI;
                EXE_HI: begin
                    if (LW'(idx) == len - LW'(1)) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx + AW'(1);
                        state_nxt = EXE_LO;
                    end
                end
                FIN:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Pin pattern for the upcoming state, registered below so outputs stay glitch-free
    always_comb begin
        io_c   = 8'h00;
        busy_c = (state_nxt != IDLE);
        done_c = (state_nxt == DONE);
        case (state_nxt)
            RST_LO:  io_c = 8'h02;
            RST_HI:  io_c = 8'h03;
            EXE_LO:  io_c = {prog[idx_nxt], 2'b00};
            EXE_HI:  io_c = {prog[idx_nxt], 2'b01};
            default: io_c = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_io_in <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cpu_io_in <= io_c;
            busy      <= busy_c;
            done      <= done_c;
        end
    end

    // CPU output settles during the cycle after its rising clock; sample at the end of it
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pending <= 1'b0;
            trace_valid <= 1'b0;
            trace_data  <= 8'h00;
        end else begin
            cap_pending <= (state == EXE_HI) && !stop;
            trace_valid <= cap_pending;
            if (cap_pending) begin
                trace_data <= cpu_io_out;
            end
        end
    end

    // Program buffer is only writable while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                prog[i] <= '0;
            end
        end else if (wr_en && state == IDLE) begin
            prog[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_hidden_cpu_driver.sv
// Directed bench for hidden_cpu_driver with a tiny CPU model that returns A0+n
// after its n-th (zero-based) rising clock edge of each run.
module tb_hidden_cpu_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [4:0] prog_len = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] cpu_io_out = 8'h00;
    logic [7:0] cpu_io_in;
    logic       busy;
    logic       done;
    logic       trace_valid;
    logic [7:0] trace_data;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int run_base = 0;

    logic [7:0] io_s [64];
    logic       busy_s [64];
    logic       done_s [64];
    logic       tv_s [64];
    logic [7:0] td_s [64];

    hidden_cpu_driver dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .cpu_io_out  (cpu_io_out),
        .cpu_io_in   (cpu_io_in),
        .busy        (busy),
        .done        (done),
        .trace_valid (trace_valid),
        .trace_data  (trace_data)
    );

    always #5 clk = ~clk;

    always @(posedge cpu_io_in[0]) begin
        cpu_io_out = 8'hA0 + 8'(edge_cnt - run_base);
        edge_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_prog(input logic [3:0] addr, input logic [5:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Leaves the bench on the negedge of the first cycle after the start edge
    task automatic pulse_start(input logic [4:0] len, input logic with_stop);
        @(negedge clk);
        run_base = edge_cnt;
        prog_len = len; start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic record(input int n, input int wr_at, input int stop_at, input int rst_at);
        for (int i = 0; i < n; i++) begin
            io_s[i] = cpu_io_in; busy_s[i] = busy; done_s[i] = done;
            tv_s[i] = trace_valid; td_s[i] = trace_data;
            wr_en = (i == wr_at); wr_addr = 4'd0; wr_data = 6'h00;
            stop  = (i == stop_at);
            rst   = (i == rst_at);
            @(negedge clk);
        end
        wr_en = 1'b0; stop = 1'b0; rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_basic [12];
        logic [7:0] exp_tr [3];
        logic [7:0] exp_one [8];
        int cnt;
        int tr;
        exp_basic = '{8'h02, 8'h03, 8'h02, 8'h03, 8'h54, 8'h55,
                      8'hA8, 8'hA9, 8'hFC, 8'hFD, 8'h00, 8'h00};
        exp_tr    = '{8'hA2, 8'hA3, 8'hA4};
        exp_one   = '{8'h02, 8'h03, 8'h02, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00};

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_io", 32'(cpu_io_in), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tv", 32'(trace_valid), 32'd0);
        check("rst_td", 32'(trace_data), 32'h00);

        // Basic run with a write attempt while busy
        write_prog(4'd0, 6'h15);
        write_prog(4'd1, 6'h2A);
        write_prog(4'd2, 6'h3F);
        pulse_start(5'd3, 1'b0);
        record(14, 3, -1, -1);
        cnt = 0; tr = 0;
        for (int i = 0; i < 12; i++) check($sformatf("basic_io%0d", i), 32'(io_s[i]), 32'(exp_basic[i]));
        for (int i = 0; i < 14; i++) begin
            if (busy_s[i]) cnt++;
            if (tv_s[i]) begin
                if (tr < 3) check($sformatf("basic_tr%0d", tr), 32'(td_s[i]), 32'(exp_tr[tr]));
                tr++;
            end
        end
        check("basic_busy_cycles", 32'(cnt), 32'd12);
        check("basic_trace_cnt", 32'(tr), 32'd3);
        check("basic_done_pos", 32'(done_s[11]), 32'd1);
        check("basic_done_tv", 32'(tv_s[11]), 32'd1);
        check("basic_done_once", 32'(done_s[10] | done_s[12]), 32'd0);

        // Second run: write ignored, then abort during the second EXE_LO
        pulse_start(5'd3, 1'b0);
        record(12, -1, 6, -1);
        check("abort_first_instr", 32'(io_s[4]), 32'h54);
        check("abort_at_exelo", 32'(io_s[6]), 32'hA8);
        check("abort_io", 32'(io_s[7]), 32'h00);
        check("abort_busy", 32'(busy_s[7]), 32'd0);
        cnt = 0; tr = 0;
        for (int i = 0; i < 12; i++) if (done_s[i]) cnt++;
        for (int i = 7; i < 12; i++) if (tv_s[i]) tr++;
        check("abort_no_done", 32'(cnt), 32'd0);
        check("abort_trace_le1", 32'(tr <= 1), 32'd1);
        check("abort_trace_data", 32'(td_s[7]), 32'hA2);

        // Length corners and start/stop collisions
        pulse_start(5'd0, 1'b0);
        record(4, -1, -1, -1);
        check("len0_busy", 32'(busy_s[0] | busy_s[1] | busy_s[2] | busy_s[3]), 32'd0);
        pulse_start(5'd3, 1'b1);
        record(4, -1, -1, -1);
        check("startstop_busy", 32'(busy_s[0] | busy_s[1] | busy_s[2] | busy_s[3]), 32'd0);
        pulse_start(5'd20, 1'b0);
        cnt = 0; tr = 0;
        while (busy && cnt < 100) begin
            if (trace_valid) tr++;
            cnt++;
            @(negedge clk);
        end
        check("len20_busy_cycles", 32'(cnt), 32'd38);
        check("len20_traces", 32'(tr), 32'd16);

        // rst in EXE_HI clears outputs and the program buffer
        pulse_start(5'd3, 1'b0);
        record(8, -1, -1, 5);
        check("midrst_pre_exehi", 32'(io_s[5]), 32'h55);
        check("midrst_io", 32'(io_s[6]), 32'h00);
        check("midrst_busy", 32'(busy_s[6]), 32'd0);
        check("midrst_done", 32'(done_s[6]), 32'd0);
        check("midrst_tv", 32'(tv_s[6] | tv_s[7]), 32'd0);
        check("midrst_td", 32'(td_s[6]), 32'h00);
        pulse_start(5'd1, 1'b0);
        record(10, -1, -1, -1);
        for (int i = 0; i < 8; i++) check($sformatf("len1_io%0d", i), 32'(io_s[i]), 32'(exp_one[i]));
        check("len1_done", 32'(done_s[7]), 32'd1);
        check("len1_trace", 32'(tv_s[7]), 32'd1);
        check("len1_trace_data", 32'(td_s[7]), 32'hA2);
        check("len1_idle", 32'(busy_s[8]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
